// File: rtl/fifo_reader_pkg.sv
// Shared types for the show-ahead FIFO reader: occupancy state of the two-entry output buffer.
package fifo_reader_pkg;

   typedef enum logic [1:0] {
      RD_EMPTY = 2'd0,
      RD_ONE   = 2'd1,
      RD_TWO   = 2'd2
   } rd_state_e;

endpackage

// File: rtl/fifo_reader.sv
// Pops a show-ahead FIFO into a main/skid buffer so the downstream valid/ready interface
// runs one entry per cycle while the pop request never waits on the downstream ready.
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   input  logic                  i_fifo_empty,
   output logic                  o_fifo_rd_en,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic                  i_ready,
   input  logic                  i_flush,
   output logic [1:0]            o_occupancy,
   output logic [CNT_WIDTH-1:0]  o_pop_cnt
);

   rd_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] main_q, main_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  valid_q, valid_d;
   logic [1:0]            occ_q, occ_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  pop_s;
   logic                  accept_s;

   // Pop only looks at local state, so a full buffer is the only thing that stalls the FIFO.
   always_comb begin
      pop_s    = !i_rst && !i_flush && !i_fifo_empty && (state_q != RD_TWO);
      accept_s = valid_q && i_ready;
   end

   // Next-state and buffer update; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (i_flush) begin
         state_d = RD_EMPTY;
      end else begin
         case (state_q)
            RD_EMPTY: begin
               if (pop_s) begin
                  state_d = RD_ONE;
                  main_d  = i_fifo_data;
               end else begin
                  state_d = RD_EMPTY;
               end
            end
            RD_ONE: begin
               if (pop_s && accept_s) begin
                  state_d = RD_ONE;
                  main_d  = i_fifo_data;
               end else if (pop_s) begin
                  state_d = RD_TWO;
                  skid_d  = i_fifo_data;
               end else if (accept_s) begin
                  state_d = RD_EMPTY;
               end else begin
                  state_d = RD_ONE;
               end
            end
            RD_TWO: begin
               if (accept_s) begin
                  state_d = RD_ONE;
                  main_d  = skid_q;
               end else begin
                  state_d = RD_TWO;
               end
            end
            default: begin
               state_d = RD_EMPTY;
            end
         endcase
      end
   end

   // Registered output flags follow the next state so they line up with the buffer contents.
   always_comb begin
      valid_d = (state_d != RD_EMPTY);
      case (state_d)
         RD_EMPTY: occ_d = 2'd0;
         RD_ONE:   occ_d = 2'd1;
         RD_TWO:   occ_d = 2'd2;
         default:  occ_d = 2'd0;
      endcase
      if (pop_s) begin
         cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State, buffer and counter registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= RD_EMPTY;
         main_q  <= {DATA_WIDTH{1'b0}};
         skid_q  <= {DATA_WIDTH{1'b0}};
         valid_q <= 1'b0;
         occ_q   <= 2'd0;
         cnt_q   <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         valid_q <= valid_d;
         occ_q   <= occ_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_fifo_rd_en = pop_s;
   assign o_valid      = valid_q;
   assign o_data       = main_q;
   assign o_occupancy  = occ_q;
   assign o_pop_cnt    = cnt_q;

endmodule
